// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl sequencer: state encoding and default widths.
package count_ctrl_pkg;

   localparam int W_DEF  = 4;
   localparam int PW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/count_ctrl_mod_n_counter.sv
// Mod-N up counter: counts 0..n, clears to 0 on the enabled step after q==n.
module mod_n_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] n,
   output logic [W-1:0] q,
   output logic         tc
);

   logic [W-1:0] q_r;

   assign q  = q_r;
   assign tc = (q_r == n);

   // count register; clr dominates en, terminal count folds back to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= {W{1'b0}};
      end else if (clr) begin
         q_r <= {W{1'b0}};
      end else if (en) begin
         if (tc) begin
            q_r <= {W{1'b0}};
         end else begin
            q_r <= q_r + W'(1'b1);
         end
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/count_ctrl.sv
// Run sequencer for mod_n_counter: latches N and pass count on start, runs the
// counter for that many 0..N passes with pause/abort, and pulses wrap and done.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  n_in,
   input  logic [PW-1:0] passes,
   input  logic          pause,
   input  logic          abort,
   output logic [W-1:0]  a,
   output logic          busy,
   output logic          wrap,
   output logic          done,
   output logic [PW-1:0] pass_cnt
);

   state_t        state_r;
   state_t        state_n_s;
   logic [W-1:0]  n_r;
   logic [PW-1:0] passes_r;
   logic [PW-1:0] pass_cnt_r;
   logic          wrap_r;
   logic          done_r;
   logic          busy_r;
   logic          accept_s;
   logic          cnt_en_s;
   logic          cnt_clr_s;
   logic          tc_s;
   logic          last_pass_s;

   assign last_pass_s = ((pass_cnt_r + PW'(1'b1)) == passes_r);

   mod_n_counter #(.W(W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr_s),
      .en  (cnt_en_s),
      .n   (n_r),
      .q   (a),
      .tc  (tc_s)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // next-state logic, priority abort > pause > count
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if ((n_in == {W{1'b0}}) || (passes == {PW{1'b0}})) begin
                  state_n_s = DONE;
               end else begin
                  state_n_s = RUN;
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_n_s = IDLE;
            end else if (pause) begin
               state_n_s = HOLD;
            end else if (tc_s && last_pass_s) begin
               state_n_s = DONE;
            end else begin
               state_n_s = RUN;
            end
         end
         HOLD: begin
            if (abort) begin
               state_n_s = IDLE;
            end else if (!pause) begin
               state_n_s = RUN;
            end else begin
               state_n_s = HOLD;
            end
         end
         DONE:    state_n_s = IDLE;
         default: state_n_s = IDLE;
      endcase
   end

   // control strobes decoded from state and inputs
   always_comb begin
      accept_s  = 1'b0;
      cnt_en_s  = 1'b0;
      cnt_clr_s = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s  = start;
            cnt_clr_s = start;
         end
         RUN: begin
            if (abort) begin
               cnt_clr_s = 1'b1;
            end else if (!pause) begin
               cnt_en_s = 1'b1;
            end else begin
               cnt_en_s = 1'b0;
            end
         end
         HOLD: begin
            if (abort) begin
               cnt_clr_s = 1'b1;
            end else begin
               cnt_clr_s = 1'b0;
            end
         end
         DONE:    cnt_clr_s = 1'b0;
         default: cnt_clr_s = 1'b0;
      endcase
   end

   // run parameters, pass counter and registered status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         n_r        <= {W{1'b0}};
         passes_r   <= {PW{1'b0}};
         pass_cnt_r <= {PW{1'b0}};
         wrap_r     <= 1'b0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         if (accept_s) begin
            n_r        <= n_in;
            passes_r   <= passes;
            pass_cnt_r <= {PW{1'b0}};
         end else if (cnt_en_s && tc_s) begin
            pass_cnt_r <= pass_cnt_r + PW'(1'b1);
         end else begin
            pass_cnt_r <= pass_cnt_r;
         end
         wrap_r <= cnt_en_s && tc_s;
         done_r <= (state_n_s == DONE);
         busy_r <= (state_n_s == RUN) || (state_n_s == HOLD);
      end
   end

   assign wrap     = wrap_r;
   assign done     = done_r;
   assign busy     = busy_r;
   assign pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: hand-written vector table, directed
// corner-case sequences, and random traffic against a step-counting model.
module tb_count_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] n_in = 4'd0;
   logic [3:0] passes = 4'd0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] a;
   logic       busy;
   logic       wrap;
   logic       done;
   logic [3:0] pass_cnt;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model: a run is "steps" counting edges out of passes*(N+1)
   bit m_active, m_held, m_done, m_wrap;
   int m_n, m_p, m_steps;

   count_ctrl #(.W(4), .PW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .n_in(n_in), .passes(passes),
      .pause(pause), .abort(abort), .a(a), .busy(busy), .wrap(wrap),
      .done(done), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_step(input bit r, input bit s, input int n, input int p,
                             input bit pz, input bit ab);
      if (r) begin
         m_active = 0; m_held = 0; m_done = 0; m_wrap = 0;
         m_n = 0; m_p = 0; m_steps = 0;
      end else begin
         m_wrap = 0;
         if (m_done) begin
            m_done = 0;
         end else if (!m_active) begin
            if (s) begin
               m_n = n; m_p = p; m_steps = 0; m_held = 0;
               if (n == 0 || p == 0) m_done = 1;
               else m_active = 1;
            end
         end else if (ab) begin
            m_active = 0; m_held = 0;
         end else if (m_held) begin
            if (!pz) m_held = 0;
         end else if (pz) begin
            m_held = 1;
         end else begin
            m_steps++;
            if (m_steps % (m_n + 1) == 0) m_wrap = 1;
            if (m_steps == m_p * (m_n + 1)) begin
               m_active = 0; m_done = 1;
            end
         end
      end
   endtask

   task automatic tick(input bit r, input bit s, input int n, input int p,
                       input bit pz, input bit ab);
      rst = r; start = s; n_in = 4'(n); passes = 4'(p); pause = pz; abort = ab;
      @(posedge clk);
      model_step(r, s, n & 15, p & 15, pz, ab);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s (t=%0d): got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ea, input int eb,
                          input int ew, input int ed, input int epc);
      chk({tag, ".a"},        int'(a),        ea);
      chk({tag, ".busy"},     int'(busy),     eb);
      chk({tag, ".wrap"},     int'(wrap),     ew);
      chk({tag, ".done"},     int'(done),     ed);
      chk({tag, ".pass_cnt"}, int'(pass_cnt), epc);
   endtask

   typedef struct {
      bit r, s; int n, p; bit pz, ab;
      int ea, eb, ew, ed, epc;
   } vec_t;

   vec_t tbl[18];

   initial begin
      //          r  s  n  p  pz ab | a  b  w  d  pc
      tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 4, 0, 0,   0, 0, 0, 1, 0};  // degenerate N=0
      tbl[2]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
      tbl[3]  = '{0, 1, 7, 0, 0, 0,   0, 0, 0, 1, 0};  // degenerate passes=0
      tbl[4]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
      tbl[5]  = '{0, 1, 2, 1, 0, 0,   0, 1, 0, 0, 0};
      tbl[6]  = '{0, 1, 9, 5, 0, 0,   1, 1, 0, 0, 0};  // start in RUN ignored
      tbl[7]  = '{0, 0, 9, 0, 0, 0,   2, 1, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1};
      tbl[9]  = '{0, 1, 3, 1, 0, 0,   0, 0, 0, 0, 1};  // start in DONE ignored
      tbl[10] = '{0, 1, 3, 2, 0, 0,   0, 1, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0};
      tbl[12] = '{0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0};
      tbl[14] = '{0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0};
      tbl[15] = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0};  // abort+pause = abort
      tbl[16] = '{1, 1, 5, 1, 0, 0,   0, 0, 0, 0, 0};  // start with rst ignored
      tbl[17] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

      for (int i = 0; i < 18; i++) begin
         tick(tbl[i].r, tbl[i].s, tbl[i].n, tbl[i].p, tbl[i].pz, tbl[i].ab);
         chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ew,
                 tbl[i].ed, tbl[i].epc);
      end

      // basic: N=11, 2 passes, n_in wiggled mid-run
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 1, 11, 2, 0, 0);
      chk_all("basic.c1", 0, 1, 0, 0, 0);
      for (int c = 2; c <= 26; c++) begin
         tick(0, 0, 3, 1, 0, 0);
         if (c == 12) chk_all("basic.c12", 11, 1, 0, 0, 0);
         if (c == 13) chk_all("basic.c13", 0, 1, 1, 0, 1);
         if (c == 24) chk_all("basic.c24", 11, 1, 0, 0, 1);
         if (c == 25) chk_all("basic.c25", 0, 0, 1, 1, 2);
         if (c == 26) chk_all("basic.c26", 0, 0, 0, 0, 2);
      end

      // pause while a==N
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 1, 3, 1, 0, 0);
      for (int c = 2; c <= 4; c++) tick(0, 0, 0, 0, 0, 0);
      chk_all("pause.pre", 3, 1, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         tick(0, 0, 0, 0, 1, 0);
         chk_all($sformatf("pause.hold%0d", c), 3, 1, 0, 0, 0);
      end
      tick(0, 0, 0, 0, 0, 0);
      chk_all("pause.release", 3, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      chk_all("pause.end", 0, 0, 1, 1, 1);

      // abort at pass_cnt=1, a=2
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 1, 5, 3, 0, 0);
      for (int c = 2; c <= 9; c++) tick(0, 0, 0, 0, 0, 0);
      chk_all("abort.pre", 2, 1, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 1);
      chk_all("abort.c1", 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 0);
      chk_all("abort.c2", 0, 0, 0, 0, 1);

      // rst while in HOLD
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 1, 4, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 1, 0);
      chk_all("hold.pre", 1, 1, 0, 0, 0);
      tick(1, 0, 0, 0, 1, 0);
      chk_all("hold.rst", 0, 0, 0, 0, 0);

      // full range N=15
      tick(0, 1, 15, 1, 0, 0);
      chk("full.c1.a", int'(a), 0);
      for (int c = 2; c <= 16; c++) begin
         tick(0, 0, 0, 0, 0, 0);
         chk($sformatf("full.c%0d.a", c), int'(a), c - 1);
      end
      tick(0, 0, 0, 0, 0, 0);
      chk_all("full.c17", 0, 0, 1, 1, 1);

      // random traffic vs model
      tick(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         tick(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 59) == 0));
         chk_all("rand",
                 m_active ? (m_steps % (m_n + 1)) : 0,
                 int'(m_active), int'(m_wrap), int'(m_done),
                 m_steps / (m_n + 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Sequencing controller for the team's mod-N up counter. It accepts a start command carrying a terminal value N and a pass count. It then runs the counter 0..N for that many passes, with pause and abort, and reports wraps, progress and completion. It sits between a host/control FSM and the counter datapath, so the counter is never free-running.

## Interface
Parameters:
- W, 4: count width; also the width of the terminal value
- PW, 4: pass-count width

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; accepted only in IDLE
- n_in  in  W  terminal value N; latched on accepted start
- passes  in  PW  number of full 0..N passes; latched on accepted start
- pause  in  1  level; freezes counting while high
- abort  in  1  level; terminates run, no done
- a  out  W  current count
- busy  out  1  high in RUN and HOLD
- wrap  out  1  one-cycle pulse in the cycle a returns N→0
- done  out  1  one-cycle pulse on normal completion
- pass_cnt  out  PW  completed passes in current/last run

## Operation
- States: IDLE, RUN, HOLD, DONE. All outputs are registered or Moore-decoded from state; there are no combinational input→output paths.
- Reset (any state, any cycle): state=IDLE, a=0, pass_cnt=0, wrap=0, done=0, busy=0, latched N=0, latched passes=0.
- IDLE:
  - On start=1, latch n_in and passes.
  - If n_in==0 or passes==0, go to DONE (degenerate run: no counting, pass_cnt=0).
  - Otherwise go to RUN with a=0 and pass_cnt=0.
- RUN, per cycle, priority abort > pause > count:
  - abort: go to IDLE, a=0, no wrap, no done. pass_cnt holds its value.
  - pause: go to HOLD. a, pass_cnt and wrap generation are frozen.
  - a<N: a=a+1.
  - a==N: a=0, wrap=1, pass_cnt=pass_cnt+1. If pass_cnt+1==passes, go to DONE; otherwise stay in RUN.
- HOLD:
  - abort: go to IDLE, a=0.
  - pause=0: return to RUN. Counting resumes on the following edge from the frozen a.
  - Otherwise stay in HOLD.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- In IDLE after a run, pass_cnt holds its final value until the next accepted start or rst.
- start outside IDLE is ignored, and so is a start that coincides with rst.
- n_in and passes are don't-care except in the cycle start is accepted. Changes mid-run have no effect.
- Arithmetic: a is unsigned mod 2^W; the compare is an exact equality a==N. N=2^W-1 gives full-range counting. pass_cnt never exceeds passes, so no overflow is possible.

## Timing
- start sampled at edge k: busy=1 and a=0 from cycle k+1.
- Each pass is N+1 RUN cycles. With no pause, the run is passes·(N+1) RUN cycles.
- wrap is high in the same cycle a first shows 0 after N. On the final pass, wrap and done are high together (the DONE cycle).
- Pause takes effect at the next edge. The value of a visible in the pause cycle's successor equals the value in the pause cycle.
- abort or rst mid-run: IDLE on the next edge, with no trailing wrap or done pulse.
- Minimum start-to-start spacing: one IDLE cycle after DONE.

## Structure
- Shared package count_ctrl_pkg holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3
  - default W and PW values
- Sub-module mod_n_counter (W):
  - ports: clk, rst, clr, en, n[W-1:0], q[W-1:0], tc
  - tc is combinational q==n
  - en advances q, or clears it to 0 when tc is high; clr has priority.
- count_ctrl contains the FSM, the N/passes latches, pass_cnt, and registered wrap/done.

## Test plan
- Basic: N=11, passes=2, start at cycle 0.
  - a=0 at cycle 1 and a=11 at cycle 12.
  - wrap at cycle 13 with pass_cnt=1; a=11 at cycle 24.
  - Cycle 25: done=1, wrap=1, pass_cnt=2, busy=0. Cycle 26: IDLE.
- Pause: N=3, passes=1, pause high for 3 cycles while a=3.
  - a holds 3 with no wrap.
  - After release, wrap and done fire together one cycle later.
- Abort: N=5, passes=3, abort asserted when pass_cnt=1 and a=2.
  - Next cycle: a=0, busy=0, no done; pass_cnt stays 1.
  - abort+pause together behaves as abort.
- Degenerate: start with n_in=0, passes=4 → DONE next cycle, done=1, pass_cnt=0, a=0, no wrap. Also with n_in=7, passes=0 → same result.
- Ignored inputs:
  - start pulsed during RUN and during DONE is ignored.
  - n_in changed mid-run does not alter the terminal value.
  - rst during HOLD returns all outputs to 0 next cycle.
- Full range: W=4, N=15, passes=1 → a steps 0..15, wrap/done at cycle 17 after start.
